// File: rtl/flag_pkg.sv
// Shared definitions for the status-flag bank: flag bit positions and the
// flag_op encodings used by the controller, the ALU and flag_bank.
package flag_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_B = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        FOP_UPD = 2'b00,
        FOP_SET = 2'b01,
        FOP_CLR = 2'b10,
        FOP_TGL = 2'b11
    } flag_op_e;

    // Next value of one masked flag bit for a given op.
    function automatic logic flag_apply_bit(input logic [1:0] op,
                                            input logic       cur,
                                            input logic       din);
        logic res;
        case (op)
            FOP_UPD: res = din;
            FOP_SET: res = 1'b1;
            FOP_CLR: res = 1'b0;
            default: res = ~cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// Register-based LIFO used as the flag shadow stack. Pop data is the current
// top entry, available combinationally from registered state. Simultaneous
// push and pop is a no-op; push when full and pop when empty are ignored.
module flag_stack
    import flag_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [SP_W-1:0]  sp_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign do_push = push_i & ~pop_i & ~full_o;
    assign do_pop  = pop_i & ~push_i & ~empty_o;
    assign wr_idx  = IDX_W'(sp_q);
    assign rd_idx  = IDX_W'(sp_q - SP_W'(1));
    assign dout_o  = mem_q[rd_idx];
    assign sp_o    = sp_q;

    // Stack pointer next-state: count up on push, down on pop.
    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    // Stack pointer register; contents are don't-care after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage, written at the current pointer on push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din_i;
        end
    end

endmodule

// File: rtl/flag_bank.sv
// Parametrised CPU status-flag register with masked ALU update, explicit
// set/clear/toggle, a LIFO shadow stack for interrupt/call entry, and sticky
// overflow/underflow error bits. A pop restores flags and discards any flag
// write issued in the same cycle.
module flag_bank
    import flag_pkg::*;
#(
    parameter  int FLAG_W = 4,
    parameter  int DEPTH  = 4,
    localparam int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              flag_rst,
    input  logic              flag_valid,
    input  logic [1:0]        flag_op,
    input  logic [FLAG_W-1:0] flag_mask,
    input  logic [FLAG_W-1:0] flag_in,
    input  logic              flag_push,
    input  logic              flag_pop,
    input  logic              flag_err_clr,
    output logic [FLAG_W-1:0] flag_out,
    output logic [SP_W-1:0]   flag_sp,
    output logic              flag_full,
    output logic              flag_empty,
    output logic              flag_ovf,
    output logic              flag_unf
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] wr_val;
    logic [FLAG_W-1:0] stk_top;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              push_only;
    logic              pop_only;
    logic              ovf_evt;
    logic              unf_evt;
    logic              restore;

    assign push_only = flag_push & ~flag_pop;
    assign pop_only  = flag_pop & ~flag_push;
    assign ovf_evt   = push_only & flag_full;
    assign unf_evt   = pop_only & flag_empty;
    assign restore   = pop_only & ~flag_empty;

    // The stack always saves the pre-update flags of the current cycle.
    flag_stack #(
        .WIDTH (FLAG_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (flag_rst),
        .push_i  (flag_push),
        .pop_i   (flag_pop),
        .din_i   (flags_q),
        .dout_o  (stk_top),
        .sp_o    (flag_sp),
        .full_o  (flag_full),
        .empty_o (flag_empty)
    );

    // Per-bit op decode; unmasked bits hold their current value.
    always_comb begin
        wr_val = flags_q;
        for (int i = 0; i < FLAG_W; i++) begin
            if (flag_mask[i]) begin
                wr_val[i] = flag_apply_bit(flag_op, flags_q[i], flag_in[i]);
            end
        end
    end

    // Priority mux: a successful pop beats a flag write; sticky errors set
    // before clear so a same-cycle error survives flag_err_clr.
    always_comb begin
        flags_d = flags_q;
        if (flag_valid) begin
            flags_d = wr_val;
        end
        if (restore) begin
            flags_d = stk_top;
        end

        ovf_d = ovf_q;
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (flag_err_clr) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (unf_evt) begin
            unf_d = 1'b1;
        end else if (flag_err_clr) begin
            unf_d = 1'b0;
        end
    end

    // Flag and error registers.
    always_ff @(posedge clk or posedge flag_rst) begin
        if (flag_rst) begin
            flags_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign flag_out = flags_q;
    assign flag_ovf = ovf_q;
    assign flag_unf = unf_q;

endmodule

// File: tb/tb_flag_bank.sv
// Bench for flag_bank: directed scenarios plus randomized traffic against a
// queue-based reference model, and a legacy 3-flag instance.
module tb_flag_bank;
    import flag_pkg::*;

    localparam int W   = 4;
    localparam int D   = 2;
    localparam int SPW = $clog2(D + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic [1:0]     op;
    logic [W-1:0]   mask;
    logic [W-1:0]   din;
    logic           push;
    logic           pop;
    logic           eclr;
    logic [W-1:0]   fout;
    logic [SPW-1:0] sp;
    logic           full;
    logic           empty;
    logic           ovf;
    logic           unf;

    logic [2:0]     l_in;
    logic [2:0]     l_out;
    logic [0:0]     l_sp;
    logic           l_full;
    logic           l_empty;
    logic           l_ovf;
    logic           l_unf;
    logic [2:0]     l_exp;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] m_flags;
    logic [W-1:0] m_stk[$];
    logic         m_ovf;
    logic         m_unf;

    always #5 clk = ~clk;

    flag_bank #(.FLAG_W(W), .DEPTH(D)) dut (
        .clk          (clk),
        .flag_rst     (rst),
        .flag_valid   (valid),
        .flag_op      (op),
        .flag_mask    (mask),
        .flag_in      (din),
        .flag_push    (push),
        .flag_pop     (pop),
        .flag_err_clr (eclr),
        .flag_out     (fout),
        .flag_sp      (sp),
        .flag_full    (full),
        .flag_empty   (empty),
        .flag_ovf     (ovf),
        .flag_unf     (unf)
    );

    flag_bank #(.FLAG_W(3), .DEPTH(1)) dut_leg (
        .clk          (clk),
        .flag_rst     (rst),
        .flag_valid   (1'b1),
        .flag_op      (FOP_UPD),
        .flag_mask    (3'b111),
        .flag_in      (l_in),
        .flag_push    (1'b0),
        .flag_pop     (1'b0),
        .flag_err_clr (1'b0),
        .flag_out     (l_out),
        .flag_sp      (l_sp),
        .flag_full    (l_full),
        .flag_empty   (l_empty),
        .flag_ovf     (l_ovf),
        .flag_unf     (l_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Reference behaviour for one clock edge, from the rules as written.
    task automatic model_edge(input logic v, input logic [1:0] o, input logic [W-1:0] m,
                              input logic [W-1:0] d, input logic pu, input logic po,
                              input logic c);
        logic [W-1:0] nf;
        logic         e_ovf;
        logic         e_unf;
        nf    = m_flags;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        if (v) begin
            case (o)
                2'b00:   nf = (m_flags & ~m) | (d & m);
                2'b01:   nf = m_flags | m;
                2'b10:   nf = m_flags & ~m;
                default: nf = m_flags ^ m;
            endcase
        end
        if (pu && !po) begin
            if (m_stk.size() == D) e_ovf = 1'b1;
            else m_stk.push_back(m_flags);
        end
        if (po && !pu) begin
            if (m_stk.size() == 0) e_unf = 1'b1;
            else nf = m_stk.pop_back();
        end
        m_ovf   = e_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf   = e_unf ? 1'b1 : (c ? 1'b0 : m_unf);
        m_flags = nf;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flags"}, 32'(fout), 32'(m_flags));
        chk({tag, ".sp"},    32'(sp), 32'(m_stk.size()));
        chk({tag, ".full"},  32'(full), 32'(m_stk.size() == D));
        chk({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
        chk({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
        chk({tag, ".unf"},   32'(unf), 32'(m_unf));
    endtask

    task automatic step(input string tag, input logic v, input logic [1:0] o,
                        input logic [W-1:0] m, input logic [W-1:0] d,
                        input logic pu, input logic po, input logic c);
        valid = v; op = o; mask = m; din = d; push = pu; pop = po; eclr = c;
        @(posedge clk);
        model_edge(v, o, m, d, pu, po, c);
        #1;
        check_all(tag);
        valid = 1'b0; push = 1'b0; pop = 1'b0; eclr = 1'b0;
    endtask

    task automatic lstep(input logic [2:0] v);
        l_in = v;
        chk("leg_lag", 32'(l_out), 32'(l_exp));
        @(posedge clk);
        l_exp = v;
        #1;
        chk("leg", 32'(l_out), 32'(l_exp));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; op = 2'b00; mask = '0; din = '0;
        push = 1'b0; pop = 1'b0; eclr = 1'b0; l_in = '0; l_exp = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset");

        // Masked ops
        step("upd",   1, FOP_UPD, 4'b0101, 4'b1111, 0, 0, 0); chk("upd_c", 32'(fout), 32'h5);
        step("set",   1, FOP_SET, 4'b1000, 4'b0000, 0, 0, 0); chk("set_c", 32'(fout), 32'hD);
        step("clr",   1, FOP_CLR, 4'b0001, 4'b0000, 0, 0, 0); chk("clr_c", 32'(fout), 32'hC);
        step("tgl",   1, FOP_TGL, 4'b0011, 4'b0000, 0, 0, 0); chk("tgl_c", 32'(fout), 32'hF);
        step("inval", 0, FOP_TGL, 4'b1111, 4'b0000, 0, 0, 0); chk("inval_c", 32'(fout), 32'hF);

        // Push with same-cycle update saves pre-update value
        step("ld3",   1, FOP_UPD, 4'b1111, 4'b0011, 0, 0, 0);
        step("pushu", 1, FOP_UPD, 4'b1111, 4'b1100, 1, 0, 0);
        chk("pushu_c", 32'(fout), 32'hC); chk("pushu_sp", 32'(sp), 32'd1);
        step("popr",  0, FOP_UPD, 4'b0000, 4'b0000, 0, 1, 0);
        chk("popr_c", 32'(fout), 32'h3); chk("popr_sp", 32'(sp), 32'd0);

        // Overflow
        for (int i = 0; i < 3; i++) step("push3", 0, FOP_UPD, 4'b0, 4'b0, 1, 0, 0);
        chk("ovf_c", 32'(ovf), 32'd1); chk("full_c", 32'(full), 32'd1);
        step("ovfhold", 0, FOP_UPD, 4'b0, 4'b0, 0, 0, 0);
        step("ovfclr",  0, FOP_UPD, 4'b0, 4'b0, 0, 0, 1);
        chk("ovfclr_c", 32'(ovf), 32'd0);

        // Underflow and priority
        step("pop1", 0, FOP_UPD, 4'b0, 4'b0, 0, 1, 0);
        step("pop2", 0, FOP_UPD, 4'b0, 4'b0, 0, 1, 0);
        step("unf",  0, FOP_UPD, 4'b0, 4'b0, 0, 1, 0);
        chk("unf_c", 32'(unf), 32'd1); chk("unf_flags", 32'(fout), 32'h3);
        step("ld6",  1, FOP_UPD, 4'b1111, 4'b0110, 0, 0, 0);
        step("psh6", 0, FOP_UPD, 4'b0, 4'b0, 1, 0, 0);
        step("popset", 1, FOP_SET, 4'b1111, 4'b0, 0, 1, 0);
        chk("popset_c", 32'(fout), 32'h6);
        step("pushpop", 1, FOP_CLR, 4'b0001, 4'b0, 1, 1, 0);
        chk("pushpop_sp", 32'(sp), 32'd0); chk("pushpop_ovf", 32'(ovf), 32'd0);
        step("setwins", 0, FOP_UPD, 4'b0, 4'b0, 0, 1, 1);
        chk("setwins_c", 32'(unf), 32'd1);
        step("unfclr", 0, FOP_UPD, 4'b0, 4'b0, 0, 0, 1);
        chk("unfclr_c", 32'(unf), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-cycle
        step("pre_ar", 1, FOP_SET, 4'b1111, 4'b0, 0, 0, 0);
        step("pre_ar2", 0, FOP_UPD, 4'b0, 4'b0, 1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Legacy 3-flag behaviour: C, then B, then Z
        l_exp = l_out;
        lstep(3'b001); lstep(3'b001); lstep(3'b000);
        lstep(3'b100); lstep(3'b100); lstep(3'b000);
        lstep(3'b010); lstep(3'b010); lstep(3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
